// File: rtl/joy_scanner_if.sv
// joy_scanner_if: scan request/snapshot handshake plus the NES-side read bus.
// The master is the NES core / frame logic; the slave is the scanner.
interface joy_scanner_if #(
  parameter int NUM_PADS = 2,
  parameter int PAD_BITS = 8
);
  logic                         scan_start;
  logic                         valid;
  logic                         busy;
  logic [NUM_PADS*PAD_BITS-1:0] buttons;
  logic                         nes_strobe;
  logic                         nes_clock;
  logic [NUM_PADS-1:0]          nes_data;

  modport master (
    output scan_start,
    output nes_strobe,
    output nes_clock,
    input  valid,
    input  busy,
    input  buttons,
    input  nes_data
  );

  modport slave (
    input  scan_start,
    input  nes_strobe,
    input  nes_clock,
    output valid,
    output busy,
    output buttons,
    output nes_data
  );
endinterface

// File: rtl/joy_scanner.sv
// joy_scanner: autonomous NES/SNES pad poller; completed scans are served to
// the NES core through per-pad shadow shift registers.
module joy_scanner #(
  parameter int NUM_PADS = 2,
  parameter int PAD_BITS = 8,
  parameter int CLK_DIV  = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                pad_strobe,
  output logic                pad_clock,
  input  logic [NUM_PADS-1:0] pad_data,
  joy_scanner_if.slave        bus
);
  // state     | meaning
  // S_IDLE    | waiting for scan_start
  // S_STROBE  | pad_strobe high for 2*CLK_DIV cycles
  // S_SETTLE  | strobe low for CLK_DIV cycles, bit 0 sampled on last cycle
  // S_CLK_HI  | pad_clock high for CLK_DIV cycles
  // S_CLK_LO  | pad_clock low for CLK_DIV cycles, next bit sampled on last cycle
  // S_DONE    | capture copied to buttons, valid pulses next cycle
  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_SETTLE,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  localparam int PH_W  = $clog2(2*CLK_DIV);
  localparam int BIT_W = $clog2(PAD_BITS);

  localparam logic [PH_W-1:0]  PH_LONG  = PH_W'(2*CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_SHORT = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(PAD_BITS - 2);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sample;
  logic              done;
  logic              pad_strobe_c;
  logic              pad_clock_c;

  logic [NUM_PADS-1:0]               sync_q1, sync_q2;
  logic [NUM_PADS-1:0][PAD_BITS-1:0] cap_q;
  logic [NUM_PADS-1:0][PAD_BITS-1:0] buttons_q;
  logic [NUM_PADS-1:0][PAD_BITS-1:0] shadow_q;
  logic                              valid_q;
  logic                              nes_clk_prev_q;
  logic                              nes_fall;
  logic [NUM_PADS-1:0]               nes_data_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  // Phase counter is reloaded on every state change and counts down to zero.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    sample       = 1'b0;
    done         = 1'b0;
    pad_strobe_c = 1'b0;
    pad_clock_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.scan_start) begin
          state_d = S_STROBE;
          phase_d = PH_LONG;
        end
      end
      S_STROBE: begin
        pad_strobe_c = 1'b1;
        if (phase_q == '0) begin
          state_d = S_SETTLE;
          phase_d = PH_SHORT;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      S_SETTLE: begin
        if (phase_q == '0) begin
          sample  = 1'b1;
          bit_d   = BIT_LOAD;
          phase_d = PH_SHORT;
          state_d = S_CLK_HI;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      S_CLK_HI: begin
        pad_clock_c = 1'b1;
        if (phase_q == '0) begin
          state_d = S_CLK_LO;
          phase_d = PH_SHORT;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      S_CLK_LO: begin
        if (phase_q == '0) begin
          sample  = 1'b1;
          phase_d = PH_SHORT;
          if (bit_q == '0) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q - BIT_ONE;
            state_d = S_CLK_HI;
          end
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Synchronisers idle at 1 so a disconnected pad reads as released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= pad_data;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_q     <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= done;
      if (sample) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          cap_q[p] <= {~sync_q2[p], cap_q[p][PAD_BITS-1:1]};
        end
      end
      if (done) begin
        buttons_q <= cap_q;
      end
    end
  end

  assign nes_fall = nes_clk_prev_q & ~bus.nes_clock;

  // Strobe load takes priority over a coincident read-clock fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nes_clk_prev_q <= 1'b0;
      shadow_q       <= '0;
    end else begin
      nes_clk_prev_q <= bus.nes_clock;
      for (int p = 0; p < NUM_PADS; p++) begin
        if (bus.nes_strobe) begin
          shadow_q[p] <= buttons_q[p];
        end else if (nes_fall) begin
          shadow_q[p] <= {1'b1, shadow_q[p][PAD_BITS-1:1]};
        end
      end
    end
  end

  always_comb begin
    nes_data_c = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      nes_data_c[p] = shadow_q[p][0];
    end
  end

  assign pad_strobe   = pad_strobe_c;
  assign pad_clock    = pad_clock_c;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q != S_IDLE) || valid_q;
  assign bus.buttons  = buttons_q;
  assign bus.nes_data = nes_data_c;
endmodule

// File: tb/tb_joy_scanner.sv
// tb_joy_scanner: directed checks of scan timing, snapshot, shadow reads and
// reset on a 2x8/D=4 instance and a 1x16/D=8 instance.
module tb_joy_scanner;
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  joy_scanner_if #(.NUM_PADS(2), .PAD_BITS(8))  bus_a ();
  joy_scanner_if #(.NUM_PADS(1), .PAD_BITS(16)) bus_b ();

  logic       pad_strobe_a, pad_clock_a, pad_strobe_b, pad_clock_b;
  logic [1:0] pad_data_a;
  logic [0:0] pad_data_b;

  joy_scanner #(.NUM_PADS(2), .PAD_BITS(8), .CLK_DIV(4)) dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .pad_strobe (pad_strobe_a),
    .pad_clock  (pad_clock_a),
    .pad_data   (pad_data_a),
    .bus        (bus_a)
  );

  joy_scanner #(.NUM_PADS(1), .PAD_BITS(16), .CLK_DIV(8)) dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .pad_strobe (pad_strobe_b),
    .pad_clock  (pad_clock_b),
    .pad_data   (pad_data_b),
    .bus        (bus_b)
  );

  // Pad models: latch on strobe rise, shift on pad_clock rise, active-low out.
  logic [7:0]  pad_val0 = 8'h00, pad_val1 = 8'h00, sr0 = 8'h00, sr1 = 8'h00;
  logic [15:0] pad_val_b = 16'h0000, sr_b = 16'h0000;

  always @(posedge pad_strobe_a or posedge pad_clock_a) begin
    if (pad_strobe_a) begin
      sr0 = pad_val0;
      sr1 = pad_val1;
    end else begin
      sr0 = {1'b0, sr0[7:1]};
      sr1 = {1'b0, sr1[7:1]};
    end
  end
  assign pad_data_a = {~sr1[0], ~sr0[0]};

  always @(posedge pad_strobe_b or posedge pad_clock_b) begin
    if (pad_strobe_b) sr_b = pad_val_b;
    else              sr_b = {1'b0, sr_b[15:1]};
  end
  assign pad_data_b = ~sr_b[0];

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int          v_first, v_count, stb_first, stb_hi, clk_rises, clk_hi, clk_first_rise, clk_last_fall;
  logic        busy0, busy_at_valid, busy_after;
  logic [15:0] btn_at_valid;
  logic [1:0]  nd_at_valid, nd_after;

  // Starts a scan on dut_a; index i counts posedges after E0 (i=0 is just after E0).
  task automatic scan_a(input int restart_at, input int ncyc);
    logic prev_clk;
    v_first = -1; v_count = 0; stb_first = -1; stb_hi = 0;
    clk_rises = 0; clk_hi = 0; clk_first_rise = -1; clk_last_fall = -1;
    busy0 = 1'bx; busy_at_valid = 1'bx; busy_after = 1'bx;
    btn_at_valid = 'x; nd_at_valid = 'x; nd_after = 'x;
    prev_clk = 1'b0;
    @(negedge clock);
    bus_a.scan_start = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      bus_a.scan_start = (i == restart_at);
      if (i == 0) busy0 = bus_a.busy;
      if (pad_strobe_a) begin
        stb_hi++;
        if (stb_first < 0) stb_first = i;
      end
      if (pad_clock_a) clk_hi++;
      if (pad_clock_a && !prev_clk) begin
        clk_rises++;
        if (clk_first_rise < 0) clk_first_rise = i;
      end
      if (!pad_clock_a && prev_clk) clk_last_fall = i;
      prev_clk = pad_clock_a;
      if (bus_a.valid) begin
        v_count++;
        if (v_first < 0) begin
          v_first       = i;
          busy_at_valid = bus_a.busy;
          btn_at_valid  = bus_a.buttons;
          nd_at_valid   = bus_a.nes_data;
        end
      end
      if (v_first >= 0 && i == v_first + 1) begin
        busy_after = bus_a.busy;
        nd_after   = bus_a.nes_data;
      end
    end
    bus_a.scan_start = 1'b0;
  endtask

  logic [9:0]  exp_rd0 = 10'b11_0101_1010;
  logic [9:0]  exp_rd1 = 10'b11_1100_0011;
  int          cnt_valid, cnt_busy, b_first, b_cnt;
  logic        b_busy0;
  logic [15:0] b_btn;

  initial begin
    bus_a.scan_start = 1'b0; bus_a.nes_strobe = 1'b0; bus_a.nes_clock = 1'b0;
    bus_b.scan_start = 1'b0; bus_b.nes_strobe = 1'b0; bus_b.nes_clock = 1'b0;
    pad_val0 = 8'h5A; pad_val1 = 8'hC3; pad_val_b = 16'hA5F0;

    // Reset applied before any clock edge must already clear outputs.
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_busy",    32'(bus_a.busy),     32'd0);
    check("rst_async_buttons", 32'(bus_a.buttons),  32'd0);
    check("rst_async_nes",     32'(bus_a.nes_data), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_valid",  32'(bus_a.valid),  32'd0);
    check("rst_strobe", 32'(pad_strobe_a), 32'd0);
    check("rst_clock",  32'(pad_clock_a),  32'd0);

    // Scan 1: 0x5A / 0xC3.
    scan_a(-1, 100);
    check("s1_valid_at",    32'(v_first),        32'd69);
    check("s1_valid_count", 32'(v_count),        32'd1);
    check("s1_buttons",     32'(btn_at_valid),   32'hC35A);
    check("s1_busy_start",  32'(busy0),          32'd1);
    check("s1_busy_valid",  32'(busy_at_valid),  32'd1);
    check("s1_busy_after",  32'(busy_after),     32'd0);
    check("s1_strobe_rise", 32'(stb_first),      32'd0);
    check("s1_strobe_wide", 32'(stb_hi),         32'd8);
    check("s1_clk_pulses",  32'(clk_rises),      32'd7);
    check("s1_clk_high",    32'(clk_hi),         32'd28);
    check("s1_clk_first",   32'(clk_first_rise), 32'd12);
    check("s1_clk_last_fl", 32'(clk_last_fall),  32'd64);

    // NES read: strobe 2 cycles with a read-clock fall inside it (load wins).
    @(negedge clock); bus_a.nes_strobe = 1'b1; bus_a.nes_clock = 1'b1;
    @(negedge clock); bus_a.nes_clock = 1'b0;
    @(negedge clock); bus_a.nes_strobe = 1'b0;
    @(negedge clock);
    check("nes_read0", 32'(bus_a.nes_data), 32'({exp_rd1[0], exp_rd0[0]}));
    for (int j = 1; j < 10; j++) begin
      bus_a.nes_clock = 1'b1;
      @(negedge clock); bus_a.nes_clock = 1'b0;
      @(negedge clock);
      check($sformatf("nes_read%0d", j), 32'(bus_a.nes_data), 32'({exp_rd1[j], exp_rd0[j]}));
    end

    // Scan 2: new pattern, scan_start re-pulsed at cycle 20 is ignored.
    pad_val0 = 8'h81; pad_val1 = 8'h3C;
    scan_a(20, 150);
    check("s2_valid_at",    32'(v_first),      32'd69);
    check("s2_valid_count", 32'(v_count),      32'd1);
    check("s2_buttons",     32'(btn_at_valid), 32'h3C81);

    // Reset at cycle 40 of a scan.
    pad_val0 = 8'hFF; pad_val1 = 8'h00;
    @(negedge clock); bus_a.scan_start = 1'b1;
    @(posedge clock); #1 bus_a.scan_start = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("r_pre_busy", 32'(bus_a.busy),     32'd1);
    check("r_pre_nes",  32'(bus_a.nes_data), 32'd3);
    reset_n = 1'b0;
    #1;
    check("r_busy",    32'(bus_a.busy),     32'd0);
    check("r_valid",   32'(bus_a.valid),    32'd0);
    check("r_strobe",  32'(pad_strobe_a),   32'd0);
    check("r_clock",   32'(pad_clock_a),    32'd0);
    check("r_buttons", 32'(bus_a.buttons),  32'd0);
    check("r_nes",     32'(bus_a.nes_data), 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    cnt_valid = 0; cnt_busy = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (bus_a.valid) cnt_valid++;
      if (bus_a.busy)  cnt_busy++;
    end
    check("r_no_valid", 32'(cnt_valid), 32'd0);
    check("r_no_busy",  32'(cnt_busy),  32'd0);

    // Scan 3 with nes_strobe held: buttons 0 -> 0x00FF seen one cycle after valid.
    @(negedge clock); bus_a.nes_strobe = 1'b1;
    scan_a(-1, 80);
    check("s3_valid_at",  32'(v_first),      32'd69);
    check("s3_buttons",   32'(btn_at_valid), 32'h00FF);
    check("s3_nes_valid", 32'(nd_at_valid),  32'd0);
    check("s3_nes_after", 32'(nd_after),     32'd1);
    @(negedge clock); bus_a.nes_strobe = 1'b0;

    // SNES instance: 1 pad, 16 bits, D=8.
    @(negedge clock); bus_b.scan_start = 1'b1;
    @(posedge clock); #1 bus_b.scan_start = 1'b0;
    b_first = -1; b_cnt = 0; b_busy0 = bus_b.busy; b_btn = 'x;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      if (bus_b.valid) begin
        b_cnt++;
        if (b_first < 0) begin
          b_first = i;
          b_btn   = bus_b.buttons;
        end
      end
    end
    check("b_busy_start",  32'(b_busy0), 32'd1);
    check("b_valid_at",    32'(b_first), 32'd265);
    check("b_valid_count", 32'(b_cnt),   32'd1);
    check("b_buttons",     32'(b_btn),   32'hA5F0);
    @(negedge clock); bus_b.nes_strobe = 1'b1;
    @(negedge clock); bus_b.nes_strobe = 1'b0;
    @(negedge clock);
    check("b_nes_bit0", 32'(bus_b.nes_data), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus_b.nes_clock = 1'b1;
      @(negedge clock); bus_b.nes_clock = 1'b0;
      @(negedge clock);
    end
    check("b_nes_bit4", 32'(bus_b.nes_data), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end
endmodule
